// File: rtl/instr_dispatch.sv
// Instruction dispatch stage: decodes fetched instructions, issues commands to
// accelerator units over valid/ready, tracks unit busy flags, barriers and HALT.
module instr_dispatch #(
  parameter int NUM_UNITS = 4,
  parameter int PAYLOAD_W = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 instr_vld,
  input  logic                 start,
  output logic                 inc_pc,
  output logic [NUM_UNITS-1:0] cmd_vld,
  input  logic [NUM_UNITS-1:0] cmd_rdy,
  output logic [PAYLOAD_W-1:0] cmd_data,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] busy,
  output logic                 halted,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_DECODE,
    S_ISSUE,
    S_BARRIER,
    S_HALTED,
    S_RETIRE
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CMD  = 4'h1;
  localparam logic [3:0] OP_WAIT = 4'h2;

  state_t               state, state_next;
  logic [1:0]           unit;
  logic [NUM_UNITS-1:0] unit_oh;
  logic [NUM_UNITS-1:0] accept;
  logic [NUM_UNITS-1:0] wait_mask;
  logic                 capture;
  logic                 set_err;
  logic                 is_halt;

  assign is_halt   = instr[30] & instr[29];
  // The captured payload doubles as the barrier mask for WAIT instructions.
  assign wait_mask = cmd_data[NUM_UNITS-1:0];

  always_comb begin
    unit_oh       = '0;
    unit_oh[unit] = 1'b1;
  end

  // A command is only offered once the target unit has drained its previous one.
  assign cmd_vld = (state == S_ISSUE && !busy[unit]) ? unit_oh : '0;
  assign accept  = cmd_vld & cmd_rdy;
  assign inc_pc  = (state == S_RETIRE);
  assign halted  = (state == S_BOOT) || (state == S_HALTED);

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      S_BOOT:    if (start) state_next = S_DECODE;
      S_DECODE: begin
        if (instr_vld) begin
          capture = 1'b1;
          if (is_halt) begin
            state_next = S_HALTED;
          end else begin
            unique case (instr[31:28])
              OP_NOP:  state_next = S_RETIRE;
              OP_CMD:  state_next = S_ISSUE;
              OP_WAIT: state_next = S_BARRIER;
              default: begin
                set_err    = 1'b1;
                state_next = S_RETIRE;
              end
            endcase
          end
        end
      end
      S_ISSUE:   if (|accept) state_next = S_RETIRE;
      S_BARRIER: if ((busy & wait_mask) == '0) state_next = S_RETIRE;
      S_HALTED:  if (start) state_next = S_RETIRE;
      S_RETIRE:  state_next = S_DECODE;
      default:   state_next = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      unit     <= '0;
      cmd_data <= '0;
      busy     <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      // Accept wins over a coincident done on the same unit.
      busy  <= (busy & ~unit_done) | accept;
      err   <= err | set_err;
      if (capture) begin
        unit     <= instr[27:26];
        cmd_data <= instr[PAYLOAD_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: table-driven single-instruction
// vectors plus directed sequences for stalls, barriers, HALT and reset.
module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_vld;
  logic        start;
  logic        inc_pc;
  logic [3:0]  cmd_vld;
  logic [3:0]  cmd_rdy;
  logic [25:0] cmd_data;
  logic [3:0]  unit_done;
  logic [3:0]  busy;
  logic        halted;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  rdy;
    int          lat;
    logic [3:0]  vld;
    logic [25:0] data;
    logic        err;
    logic [3:0]  busy;
  } vec_t;

  vec_t vecs[10];

  instr_dispatch #(.NUM_UNITS(4), .PAYLOAD_W(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .instr_vld (instr_vld),
    .start     (start),
    .inc_pc    (inc_pc),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_data  (cmd_data),
    .unit_done (unit_done),
    .busy      (busy),
    .halted    (halted),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge of a RETIRE (or boot-start) cycle: present one
  // instruction and measure cycles until its inc_pc.
  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    logic [3:0]  vld_seen;
    logic [25:0] data_seen;
    instr     = v.instr;
    instr_vld = 1'b1;
    cmd_rdy   = v.rdy;
    lat       = 0;
    vld_seen  = '0;
    data_seen = '0;
    do begin
      step();
      lat++;
      if (cmd_vld != 4'h0 && vld_seen == 4'h0) begin
        vld_seen  = cmd_vld;
        data_seen = cmd_data;
      end
    end while (!inc_pc && lat < 50);
    cmd_rdy = 4'h0;
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d cmd_vld", idx), 64'(vld_seen), 64'(v.vld));
    if (v.vld != 4'h0) check($sformatf("v%0d cmd_data", idx), 64'(data_seen), 64'(v.data));
    check($sformatf("v%0d err", idx), 64'(err), 64'(v.err));
    check($sformatf("v%0d busy", idx), 64'(busy), 64'(v.busy));
  endtask

  // Setup helper: retire one instruction without latency expectations.
  task automatic run_to_retire(input logic [31:0] ins, input logic [3:0] rdy, input string name);
    int n;
    instr     = ins;
    instr_vld = 1'b1;
    cmd_rdy   = rdy;
    n         = 0;
    do begin
      step();
      n++;
    end while (!inc_pc && n < 50);
    cmd_rdy = 4'h0;
    check({name, " retired"}, 64'(inc_pc), 64'(1));
  endtask

  initial begin
    logic        seen;
    logic [31:0] halt_ops[2];

    vecs[0] = '{32'h0000_0000, 4'hF, 2, 4'h0, 26'h0,       1'b0, 4'b0000};
    vecs[1] = '{32'h1400_0ABC, 4'h2, 3, 4'h2, 26'h0ABC,    1'b0, 4'b0010};
    vecs[2] = '{32'h1C12_3456, 4'hF, 3, 4'h8, 26'h0123456, 1'b0, 4'b1010};
    vecs[3] = '{32'h2000_0000, 4'hF, 3, 4'h0, 26'h0,       1'b0, 4'b1010};
    vecs[4] = '{32'h2000_0005, 4'hF, 3, 4'h0, 26'h0,       1'b0, 4'b1010};
    vecs[5] = '{32'h13FF_FFFF, 4'h1, 3, 4'h1, 26'h3FFFFFF, 1'b0, 4'b1011};
    vecs[6] = '{32'h3000_0000, 4'hF, 2, 4'h0, 26'h0,       1'b1, 4'b1011};
    vecs[7] = '{32'h0FFF_FFFF, 4'hF, 2, 4'h0, 26'h0,       1'b1, 4'b1011};
    vecs[8] = '{32'hA000_0000, 4'hF, 2, 4'h0, 26'h0,       1'b1, 4'b1011};
    vecs[9] = '{32'h5000_0000, 4'hF, 2, 4'h0, 26'h0,       1'b1, 4'b1011};
    halt_ops[0] = 32'h6000_0000;
    halt_ops[1] = 32'hE000_0000;

    rst_n     = 1'b0;
    instr     = 32'h0;
    instr_vld = 1'b0;
    start     = 1'b0;
    cmd_rdy   = 4'h0;
    unit_done = 4'h0;
    #12;
    check("rst halted",   64'(halted),   64'(1));
    check("rst inc_pc",   64'(inc_pc),   64'(0));
    check("rst cmd_vld",  64'(cmd_vld),  64'(0));
    check("rst cmd_data", 64'(cmd_data), 64'(0));
    check("rst busy",     64'(busy),     64'(0));
    check("rst err",      64'(err),      64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // BOOT ignores valid instructions until start.
    instr_vld = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (inc_pc || !halted) seen = 1'b1;
    end
    check("boot idle", 64'(seen), 64'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    check("boot halted drop", 64'(halted),  64'(0));
    check("boot no early inc", 64'(inc_pc), 64'(0));
    check("boot cmd_vld",     64'(cmd_vld), 64'(0));
    step();
    check("boot inc_pc +2",   64'(inc_pc),  64'(1));
    check("boot cmd_vld idle", 64'(cmd_vld), 64'(0));

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Busy stall and back-pressure on unit 1.
    instr   = 32'h1400_0123;
    cmd_rdy = 4'h0;
    step();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cmd_vld != 4'h0) seen = 1'b1;
    end
    check("stall cmd_vld low", 64'(seen), 64'(0));
    unit_done = 4'b0010;
    step();
    unit_done = 4'h0;
    check("stall vld after done", 64'(cmd_vld),  64'(4'b0010));
    check("stall data",           64'(cmd_data), 64'(26'h0123));
    check("stall busy cleared",   64'(busy),     64'(4'b1001));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_vld != 4'b0010 || cmd_data != 26'h0123 || inc_pc) seen = 1'b1;
    end
    check("backpressure stable", 64'(seen), 64'(0));
    cmd_rdy   = 4'b0010;
    unit_done = 4'b0010;
    step();
    cmd_rdy   = 4'h0;
    unit_done = 4'h0;
    check("accept+done inc_pc", 64'(inc_pc), 64'(1));
    check("accept+done busy",   64'(busy),   64'(4'b1011));

    // Barrier on units 0 and 2.
    unit_done = 4'hF;
    instr_vld = 1'b0;
    step();
    unit_done = 4'h0;
    check("clear all busy", 64'(busy), 64'(0));
    run_to_retire(32'h1000_0000, 4'hF, "cmd u0");
    run_to_retire(32'h1800_0000, 4'hF, "cmd u2");
    check("barrier busy setup", 64'(busy), 64'(4'b0101));
    instr = 32'h2000_0005;
    step();
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (inc_pc) seen = 1'b1;
    end
    check("barrier holds both", 64'(seen), 64'(0));
    unit_done = 4'b0001;
    step();
    unit_done = 4'h0;
    check("barrier busy after u0", 64'(busy), 64'(4'b0100));
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (inc_pc) seen = 1'b1;
    end
    check("barrier holds u2", 64'(seen), 64'(0));
    unit_done = 4'b0100;
    step();
    unit_done = 4'h0;
    check("barrier M+1 inc_pc", 64'(inc_pc), 64'(0));
    check("barrier M+1 busy",   64'(busy),   64'(0));
    step();
    check("barrier M+2 inc_pc", 64'(inc_pc), 64'(1));

    // HALT variants.
    for (int h = 0; h < 2; h++) begin
      instr = halt_ops[h];
      step();
      check($sformatf("halt%0d decode halted", h), 64'(halted), 64'(0));
      step();
      check($sformatf("halt%0d halted", h), 64'(halted), 64'(1));
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (inc_pc || !halted) seen = 1'b1;
      end
      check($sformatf("halt%0d parked", h), 64'(seen), 64'(0));
      start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("halt%0d release inc_pc", h), 64'(inc_pc), 64'(1));
      check($sformatf("halt%0d release halted", h), 64'(halted), 64'(0));
    end

    // start during DECODE is ignored.
    instr_vld = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (inc_pc || halted) seen = 1'b1;
      step();
    end
    check("start in decode ignored", 64'(seen), 64'(0));
    instr     = 32'h0000_0000;
    instr_vld = 1'b1;
    step();
    check("decode resumes", 64'(inc_pc), 64'(1));

    // Reset asserted mid-issue.
    run_to_retire(32'h1C00_0000, 4'hF, "cmd u3");
    instr   = 32'h1800_0077;
    cmd_rdy = 4'h0;
    step();
    step();
    check("pre-reset cmd_vld", 64'(cmd_vld), 64'(4'b0100));
    check("pre-reset err",     64'(err),     64'(1));
    check("pre-reset busy",    64'(busy),    64'(4'b1000));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst cmd_vld",  64'(cmd_vld),  64'(0));
    check("midrst busy",     64'(busy),     64'(0));
    check("midrst err",      64'(err),      64'(0));
    check("midrst halted",   64'(halted),   64'(1));
    check("midrst cmd_data", 64'(cmd_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("post-reset boot halted", 64'(halted), 64'(1));
    check("post-reset no inc_pc",   64'(inc_pc), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
# instr_dispatch

Control-path stage directly downstream of instruction fetch. It consumes one 32-bit instruction at a time, decodes the opcode, and issues commands to the accelerator units over a per-unit valid/ready handshake. It tracks which units are busy, stalls on barriers, and parks on HALT. It returns `inc_pc` to fetch when it retires an instruction, or to release a halt.

## Interface
- `NUM_UNITS`, default 4: number of accelerator units. Fixed at 4 because the unit field is 2 bits.
- `PAYLOAD_W`, default 26: width of the command payload, taken from `instr[25:0]`.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr` in 32: instruction from fetch.
- `instr_vld` in 1: `instr` is valid this cycle.
- `start` in 1: host pulse; begins execution after boot and releases HALT.
- `inc_pc` out 1: one-cycle pulse telling fetch to advance the PC.
- `cmd_vld` out `NUM_UNITS`: one-hot command valid, one bit per unit.
- `cmd_rdy` in `NUM_UNITS`: per-unit ready.
- `cmd_data` out `PAYLOAD_W`: payload shared by all units; valid only while some `cmd_vld` bit is high.
- `unit_done` in `NUM_UNITS`: per-unit one-cycle completion pulse.
- `busy` out `NUM_UNITS`: per-unit outstanding-command flags.
- `halted` out 1: high in BOOT and HALTED.
- `err` out 1: sticky illegal-opcode flag.

## Operation
- Opcode is `instr[31:28]`.
  - HALT: any opcode with `instr[30] & instr[29]`, i.e. 0110, 0111, 1110, 1111. Takes priority over every other decode.
  - 0000 NOP.
  - 0001 CMD: unit = `instr[27:26]`, payload = `instr[25:0]`.
  - 0010 WAIT: mask = `instr[3:0]`.
  - All other opcodes are illegal: set `err`, then retire as NOP.
- States:
  - BOOT (reset state): `halted`=1. On `start` go to DECODE.
  - DECODE: when `instr_vld`=1, capture `instr` and branch.
    - NOP or illegal → RETIRE.
    - CMD → ISSUE.
    - WAIT → BARRIER.
    - HALT → HALTED.
    - If `instr_vld`=0, stay in DECODE.
  - ISSUE: hold `cmd_vld[u]`=1 and `cmd_data`=payload while `busy[u]`=0. If `busy[u]`=1, hold `cmd_vld`=0 until the unit's done pulse clears it. When `cmd_vld[u] & cmd_rdy[u]`, set `busy[u]` and go to RETIRE.
  - BARRIER: when `(busy & mask)`==0, go to RETIRE. Mask 0 retires immediately.
  - HALTED: `halted`=1, no outputs change. On `start` go to RETIRE, which steps past the HALT instruction.
  - RETIRE: `inc_pc`=1 for exactly this cycle, then go to DECODE.
- Busy tracking:
  - `busy[u]` clears on `unit_done[u]`.
  - If accept and done coincide on the same unit in the same cycle, `busy[u]` stays 1.
  - `unit_done` on a unit that is not busy is ignored.
  - `unit_done` is honoured in every state, including HALTED and BOOT.
- `start` is ignored outside BOOT and HALTED.
- `cmd_data` is registered from the captured instruction, so it is stable throughout ISSUE regardless of `instr`.

## Timing
- Reset values: state BOOT, `halted`=1, `inc_pc`=0, `cmd_vld`=0, `cmd_data`=0, `busy`=0, `err`=0.
- All outputs are registered or decoded from registered state (Moore). There are no combinational paths from inputs to outputs.
- Reset asserted mid-operation forces the reset values immediately, even with `cmd_vld` high. Any partial handshake is abandoned.
- NOP and illegal: DECODE at cycle N, `inc_pc` at N+1, next DECODE at N+2. Throughput is one instruction per 2 cycles.
- CMD to an idle unit with `cmd_rdy`=1:
  - `cmd_vld` high at N+1; handshake completes at N+1.
  - `busy[u]` high from N+2; `inc_pc` at N+2.
  - Minimum 3 cycles per CMD.
- BARRIER: `unit_done` at cycle M (the last masked busy bit) clears `busy` at M+1. Since `busy` is registered, the barrier exit is seen at M+1 and `inc_pc` is asserted at M+2.
- HALTED: `start` at cycle S gives `inc_pc` at S+1 and `halted`=0 from S+1.
- `err` sets the cycle after the illegal opcode is decoded and is cleared only by reset.

## Test plan
- Reset and boot: assert reset, then `start` with `instr`=0x0000_0000 valid → `halted` drops; `inc_pc` pulses exactly 2 cycles after the `start` cycle; `cmd_vld`=0 throughout.
- CMD issue: `instr`=0x1400_0ABC (unit 1, payload 0xABC) with `cmd_rdy`=4'b0010 → `cmd_vld`=4'b0010 and `cmd_data`=0x0ABC for one cycle; `busy`=4'b0010 next; `inc_pc` pulses once.
- Back-pressure and busy stall:
  - Issue a second CMD to unit 1 while it is busy → `cmd_vld` stays 0.
  - `unit_done[1]` at cycle M → `cmd_vld[1]` rises at M+1.
  - Hold `cmd_rdy`=0 for 5 cycles → `cmd_vld` and `cmd_data` stay stable.
- Barrier: `busy`=4'b0101, `instr`=0x2000_0005 → no `inc_pc` until both `unit_done[0]` and `unit_done[2]` have arrived, then `inc_pc` 2 cycles after the later one. A same-cycle done+accept on a unit keeps its `busy` bit at 1.
- HALT variants: `instr`=0x6000_0000 and 0xE000_0000 → `halted`=1 and no `inc_pc` for 20 cycles; `start` → `inc_pc` on the next cycle. `start` pulsed during DECODE has no effect.
- Illegal opcode and reset mid-issue:
  - `instr`=0x3000_0000 → `err`=1 and the instruction retires like a NOP.
  - Assert reset during ISSUE → `cmd_vld`=0, `busy`=0, `err`=0, state BOOT.
